// File: rtl/multi_scoreboard_if.sv
// rtl/multi_scoreboard_if.sv - snapshot request / readout stream bundle for multi_scoreboard
//
// Purpose: groups the snapshot request and the readout stream handshake.
// Signals:
//   i_rd_req    request a snapshot (pulse)
//   i_rd_ready  consumer ready for the readout stream
//   o_rd_valid  readout word valid
//   o_rd_data   snapshot word (WIDTH bits)
//   o_rd_idx    word index: 0 = sample counter, k = channel k-1
//   o_rd_last   final word of the stream
//   o_busy      stream in progress
// Modports: master = scoreboard side, slave = consumer side.

interface multi_scoreboard_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4
) ();
    localparam int IDXW = $clog2(NUM_CH + 1);

    logic             i_rd_req;
    logic             i_rd_ready;
    logic             o_rd_valid;
    logic [WIDTH-1:0] o_rd_data;
    logic [IDXW-1:0]  o_rd_idx;
    logic             o_rd_last;
    logic             o_busy;

    modport master (
        input  i_rd_req,
        input  i_rd_ready,
        output o_rd_valid,
        output o_rd_data,
        output o_rd_idx,
        output o_rd_last,
        output o_busy
    );

    modport slave (
        output i_rd_req,
        output i_rd_ready,
        input  o_rd_valid,
        input  o_rd_data,
        input  o_rd_idx,
        input  o_rd_last,
        input  o_busy
    );
endinterface

// File: rtl/multi_scoreboard.sv
// rtl/multi_scoreboard.sv - multi-channel event scoreboard with atomic snapshot readout
//
// Purpose: counts samples and per-channel events with freeze, synchronous
// clear and sticky overflow flags; a request copies every counter into a
// snapshot bank which is then streamed out one word per handshake.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   i_freeze  hold all counters
//   i_clear   zero live counters and overflow flags (wins over freeze)
//   i_event   per-channel event strobes (NUM_CH bits)
//   o_ovf     sticky overflow flags: bit 0 = sample counter, bit k = channel k-1
//   rd        readout bundle (multi_scoreboard_if.master)
// Configuration macro: MULTI_SCOREBOARD_SAT_EN
//   defined   -> counters saturate at all-ones
//   undefined -> counters wrap modulo 2^WIDTH
// In both cases an increment from all-ones sets the matching o_ovf bit.

module multi_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_freeze,
    input  logic              i_clear,
    input  logic [NUM_CH-1:0] i_event,
    output logic [NUM_CH:0]   o_ovf,
    multi_scoreboard_if.master rd
);
    localparam int IDXW = $clog2(NUM_CH + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Counter 0 is the sample counter, counter k is channel k-1.
    logic [WIDTH-1:0] r_ctr  [0:NUM_CH];
    logic [WIDTH-1:0] r_snap [0:NUM_CH];
    logic [NUM_CH:0]  r_ovf;
    logic [IDXW-1:0]  r_idx;
    state_t           r_state;
    state_t           w_next_state;

    logic [NUM_CH:0]  w_inc;
    logic             w_valid;
    logic             w_last;
    logic             w_busy;
    logic [WIDTH-1:0] w_data;

    // The sample counter advances on every unfrozen cycle.
    assign w_inc = {i_event, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= NUM_CH; k++) begin
                r_ctr[k] <= '0;
            end
            r_ovf <= '0;
        end else if (i_clear) begin
            for (int k = 0; k <= NUM_CH; k++) begin
                r_ctr[k] <= '0;
            end
            r_ovf <= '0;
        end else if (!i_freeze) begin
            for (int k = 0; k <= NUM_CH; k++) begin
                if (w_inc[k]) begin
                    if (&r_ctr[k]) begin
                        r_ovf[k] <= 1'b1;
`ifdef MULTI_SCOREBOARD_SAT_EN
                        r_ctr[k] <= r_ctr[k];
`else
                        r_ctr[k] <= '0;
`endif
                    end else begin
                        r_ctr[k] <= r_ctr[k] + WIDTH'(1);
                    end
                end
            end
        end
    end

    // Snapshot captures the pre-update counter values, so a same-edge clear
    // or event does not leak into the streamed words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= NUM_CH; k++) begin
                r_snap[k] <= '0;
            end
            r_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rd.i_rd_req) begin
                        for (int k = 0; k <= NUM_CH; k++) begin
                            r_snap[k] <= r_ctr[k];
                        end
                        r_idx <= '0;
                    end
                end
                S_STREAM: begin
                    if (rd.i_rd_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_valid      = 1'b0;
        w_last       = 1'b0;
        w_busy       = 1'b0;
        w_data       = '0;
        case (r_state)
            S_IDLE: begin
                if (rd.i_rd_req) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                w_valid = 1'b1;
                w_busy  = 1'b1;
                w_data  = r_snap[r_idx];
                w_last  = (r_idx == LAST_IDX);
                if (rd.i_rd_ready && w_last) begin
                    w_next_state = S_IDLE;
                end
            end
        endcase
    end

    assign rd.o_rd_valid = w_valid;
    assign rd.o_rd_data  = w_data;
    assign rd.o_rd_idx   = r_idx;
    assign rd.o_rd_last  = w_last;
    assign rd.o_busy     = w_busy;
    assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_multi_scoreboard.sv
// tb/tb_multi_scoreboard.sv - directed self-checking bench for multi_scoreboard

module tb_multi_scoreboard;
    logic       clk = 1'b0;
    logic       reset;

    logic       freeze_a, clear_a;
    logic [3:0] event_a;
    logic [4:0] ovf_a;
    logic       freeze_b, clear_b;
    logic [3:0] event_b;
    logic [4:0] ovf_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_a [0:4];
    logic [3:0]  exp_b [0:4];

    multi_scoreboard_if #(.WIDTH(32), .NUM_CH(4)) if_a ();
    multi_scoreboard_if #(.WIDTH(4),  .NUM_CH(4)) if_b ();

    multi_scoreboard #(.WIDTH(32), .NUM_CH(4)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .i_freeze (freeze_a),
        .i_clear  (clear_a),
        .i_event  (event_a),
        .o_ovf    (ovf_a),
        .rd       (if_a.master)
    );

    multi_scoreboard #(.WIDTH(4), .NUM_CH(4)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .i_freeze (freeze_b),
        .i_clear  (clear_b),
        .i_event  (event_b),
        .o_ovf    (ovf_b),
        .rd       (if_b.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_a(input int n, input logic [3:0] ev);
        freeze_a = 1'b0;
        event_a  = ev;
        repeat (n) step();
        freeze_a = 1'b1;
        event_a  = '0;
    endtask

    task automatic set_exp_a(input logic [31:0] e0, e1, e2, e3, e4);
        exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3; exp_a[4] = e4;
    endtask

    // Request with ready held high; clr is asserted on the request edge.
    task automatic read_a(input string tag, input logic clr);
        if_a.i_rd_req   = 1'b1;
        if_a.i_rd_ready = 1'b1;
        clear_a         = clr;
        step();
        if_a.i_rd_req = 1'b0;
        clear_a       = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            check({tag, "_valid"}, if_a.o_rd_valid, 1'b1);
            check({tag, "_busy"},  if_a.o_busy, 1'b1);
            check({tag, "_idx"},   if_a.o_rd_idx, i);
            check({tag, "_data"},  if_a.o_rd_data, exp_a[i]);
            check({tag, "_last"},  if_a.o_rd_last, (i == 4));
            step();
        end
        check({tag, "_end_valid"}, if_a.o_rd_valid, 1'b0);
        check({tag, "_end_busy"},  if_a.o_busy, 1'b0);
    endtask

    initial begin
        int e;
        int budget;
        logic [3:0] pat;

        reset = 1'b1;
        freeze_a = 1'b1; clear_a = 1'b0; event_a = '0;
        freeze_b = 1'b1; clear_b = 1'b0; event_b = '0;
        if_a.i_rd_req = 1'b0; if_a.i_rd_ready = 1'b0;
        if_b.i_rd_req = 1'b0; if_b.i_rd_ready = 1'b0;
        repeat (2) step();

        check("rst_valid", if_a.o_rd_valid, 1'b0);
        check("rst_busy",  if_a.o_busy, 1'b0);
        check("rst_last",  if_a.o_rd_last, 1'b0);
        check("rst_idx",   if_a.o_rd_idx, 3'd0);
        check("rst_data",  if_a.o_rd_data, 32'd0);
        check("rst_ovf",   ovf_a, 5'd0);
        reset = 1'b0;
        step();

        // Basic counting
        count_a(10, 4'b0101);
        set_exp_a(32'd10, 32'd10, 32'd0, 32'd10, 32'd0);
        read_a("basic", 1'b0);

        // Freeze and clear
        clear_a = 1'b1; step(); clear_a = 1'b0;
        count_a(5, 4'b1111);
        repeat (3) step();
        count_a(2, 4'b1111);
        set_exp_a(32'd7, 32'd7, 32'd7, 32'd7, 32'd7);
        read_a("freeze", 1'b0);
        clear_a = 1'b1; step(); clear_a = 1'b0;
        check("clear_ovf", ovf_a, 5'd0);
        set_exp_a(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        read_a("clear", 1'b0);

        // Backpressure with ready pattern 1,0,0,1 and a mid-stream request
        count_a(3, 4'b0011);
        set_exp_a(32'd3, 32'd3, 32'd3, 32'd0, 32'd0);
        if_a.i_rd_req = 1'b1;
        step();
        if_a.i_rd_req = 1'b0;
        pat = 4'b1001;
        e = 0;
        budget = 0;
        while (e <= 4 && budget < 40) begin
            if_a.i_rd_ready = pat[budget % 4];
            if_a.i_rd_req   = (budget == 2);
            check("bp_valid", if_a.o_rd_valid, 1'b1);
            check("bp_idx",   if_a.o_rd_idx, e);
            check("bp_data",  if_a.o_rd_data, exp_a[e]);
            check("bp_last",  if_a.o_rd_last, (e == 4));
            if (if_a.i_rd_ready) e++;
            budget++;
            step();
        end
        if_a.i_rd_req = 1'b0;
        check("bp_count", e, 5);
        check("bp_end_valid", if_a.o_rd_valid, 1'b0);
        step();
        check("bp_no_queue", if_a.o_busy, 1'b0);
        if_a.i_rd_ready = 1'b1;

        // Snapshot atomicity: counting continues during the stream
        clear_a = 1'b1; step(); clear_a = 1'b0;
        count_a(4, 4'b1000);
        freeze_a = 1'b0;
        event_a  = 4'b1111;
        set_exp_a(32'd4, 32'd0, 32'd0, 32'd0, 32'd4);
        read_a("atomic", 1'b0);
        freeze_a = 1'b1;
        event_a  = '0;
        // request edge + 5 stream edges counted: {10,6,6,6,10}
        set_exp_a(32'd10, 32'd6, 32'd6, 32'd6, 32'd10);
        read_a("clr_snap", 1'b1);
        set_exp_a(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        read_a("clr_live", 1'b0);

        // Overflow on the 4-bit instance: 17 increments
        freeze_b = 1'b0;
        event_b  = 4'b0001;
        repeat (17) step();
        freeze_b = 1'b1;
        event_b  = '0;
        check("ovf_flags", ovf_b, 5'b00011);
`ifdef MULTI_SCOREBOARD_SAT_EN
        exp_b[0] = 4'd15; exp_b[1] = 4'd15;
`else
        exp_b[0] = 4'd1;  exp_b[1] = 4'd1;
`endif
        exp_b[2] = 4'd0; exp_b[3] = 4'd0; exp_b[4] = 4'd0;
        if_b.i_rd_req = 1'b1;
        if_b.i_rd_ready = 1'b1;
        step();
        if_b.i_rd_req = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            check("ovf_idx",  if_b.o_rd_idx, i);
            check("ovf_data", if_b.o_rd_data, exp_b[i]);
            step();
        end
        check("ovf_end_valid", if_b.o_rd_valid, 1'b0);
        clear_b = 1'b1; step(); clear_b = 1'b0;
        check("ovf_cleared", ovf_b, 5'd0);

        // Reset mid-stream after idx 2 has been delivered
        count_a(2, 4'b0001);
        if_a.i_rd_req = 1'b1;
        step();
        if_a.i_rd_req = 1'b0;
        repeat (3) step();
        check("mid_idx3", if_a.o_rd_idx, 3'd3);
        reset = 1'b1;
        #1;
        check("mrst_valid", if_a.o_rd_valid, 1'b0);
        check("mrst_busy",  if_a.o_busy, 1'b0);
        check("mrst_idx",   if_a.o_rd_idx, 3'd0);
        check("mrst_data",  if_a.o_rd_data, 32'd0);
        check("mrst_last",  if_a.o_rd_last, 1'b0);
        check("mrst_ovf",   ovf_a, 5'd0);
        step();
        reset = 1'b0;
        step();
        set_exp_a(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        read_a("post_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
